// File: rtl/pwm_decoder_if.sv
// PWM link bundle: the raw PWM pin plus the decoded speed and status flags.
interface pwm_decoder_if;
  logic       pwm_in;
  logic [2:0] speed;
  logic       speed_valid;
  logic       update;
  logic       frame_err;
  logic       stuck_high;

  modport master (
    output pwm_in,
    input  speed, speed_valid, update, frame_err, stuck_high
  );

  modport slave (
    input  pwm_in,
    output speed, speed_valid, update, frame_err, stuck_high
  );
endinterface

// File: rtl/pwm_decoder.sv
// Recovers the 3-bit speed code from a fixed-period PWM stream, confirming it
// over consecutive frames and flagging bad periods, 0% duty and stuck-high input.
//
// state   | meaning
// IDLE    | waiting for a rise to start a reference frame, no decode
// MEASURE | each rise closes a frame that is decoded and matched
module pwm_decoder #(
  parameter int PERIOD       = 32,
  parameter int CNT_W        = 7,
  parameter int SYNC_STAGES  = 2,
  parameter int MATCH_FRAMES = 2
) (
  input logic          clock,
  input logic          enable,
  pwm_decoder_if.slave link
);
  localparam int MATCH_W = $clog2(MATCH_FRAMES + 1);
  localparam logic [CNT_W-1:0]   PER_C   = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0]   STUCK_C = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0]   LOW_C   = CNT_W'(MATCH_FRAMES * PERIOD - 1);
  localparam logic [CNT_W-1:0]   SAT_C   = '1;
  localparam logic [MATCH_W-1:0] MATCH_C = MATCH_W'(MATCH_FRAMES);

  typedef enum logic [0:0] {IDLE, MEASURE} state_t;
  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pwm_s, pwm_d, rise, fall;
  logic [CNT_W-1:0]       per_cnt, high_cnt, low_run;
  logic [CNT_W:0]         steps;
  logic [2:0]             code;
  logic                   stuck_evt, timeout;

  logic [2:0]         speed_q, speed_nxt, cand_q, cand_nxt;
  logic [MATCH_W-1:0] match_q, match_nxt, match_inc;
  logic               valid_q, valid_nxt, update_q, update_nxt;
  logic               ferr_q, ferr_nxt, stuck_q, stuck_nxt;

  assign pwm_s = sync_q[SYNC_STAGES-1];
  assign rise  = pwm_s & ~pwm_d;
  assign fall  = ~pwm_s & pwm_d;

  always_ff @(posedge clock or posedge enable) begin
    if (enable) begin
      sync_q   <= '0;
      pwm_d    <= 1'b0;
      per_cnt  <= '0;
      high_cnt <= '0;
      low_run  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], link.pwm_in};
      pwm_d  <= pwm_s;
      if (rise)                  per_cnt <= CNT_W'(1);
      else if (per_cnt != SAT_C) per_cnt <= per_cnt + CNT_W'(1);
      if (rise)                            high_cnt <= CNT_W'(1);
      else if (pwm_s && high_cnt != SAT_C) high_cnt <= high_cnt + CNT_W'(1);
      if (pwm_s)                 low_run <= '0;
      else if (low_run != SAT_C) low_run <= low_run + CNT_W'(1);
    end
  end

  // Round to the nearest 4-cycle duty step so +-1 cycle of jitter decodes cleanly.
  assign steps = ({1'b0, high_cnt} + (CNT_W+1)'(2)) >> 2;
  assign code  = (steps > (CNT_W+1)'(7)) ? 3'd7 : steps[2:0];

  // The rise cycle carries the previous frame's high_cnt, so it must not count as stuck.
  assign stuck_evt = pwm_s & ~rise & (high_cnt == STUCK_C);
  assign timeout   = ~pwm_s & (low_run == LOW_C);
  assign match_inc = (match_q == MATCH_C) ? match_q : match_q + MATCH_W'(1);

  always_comb begin
    state_nxt  = state;
    speed_nxt  = speed_q;
    valid_nxt  = valid_q;
    update_nxt = 1'b0;
    ferr_nxt   = 1'b0;
    stuck_nxt  = stuck_q;
    cand_nxt   = cand_q;
    match_nxt  = match_q;
    if (fall) stuck_nxt = 1'b0;
    if (stuck_evt) begin
      stuck_nxt = 1'b1;
      valid_nxt = 1'b0;
      match_nxt = '0;
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (rise) state_nxt = MEASURE;
        end
        MEASURE: begin
          if (rise) begin
            if (per_cnt == PER_C) begin
              if (code == cand_q) begin
                match_nxt = match_inc;
              end else begin
                cand_nxt  = code;
                match_nxt = MATCH_W'(1);
              end
              if (match_nxt == MATCH_C) begin
                speed_nxt  = cand_nxt;
                valid_nxt  = 1'b1;
                update_nxt = (cand_nxt != speed_q) || !valid_q;
              end
            end else begin
              ferr_nxt  = 1'b1;
              match_nxt = '0;
            end
          end else if (timeout) begin
            speed_nxt  = 3'd0;
            valid_nxt  = 1'b1;
            update_nxt = (speed_q != 3'd0) || !valid_q;
            match_nxt  = '0;
            state_nxt  = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge enable) begin
    if (enable) begin
      state    <= IDLE;
      speed_q  <= '0;
      valid_q  <= 1'b0;
      update_q <= 1'b0;
      ferr_q   <= 1'b0;
      stuck_q  <= 1'b0;
      cand_q   <= '0;
      match_q  <= '0;
    end else begin
      state    <= state_nxt;
      speed_q  <= speed_nxt;
      valid_q  <= valid_nxt;
      update_q <= update_nxt;
      ferr_q   <= ferr_nxt;
      stuck_q  <= stuck_nxt;
      cand_q   <= cand_nxt;
      match_q  <= match_nxt;
    end
  end

  assign link.speed       = speed_q;
  assign link.speed_valid = valid_q;
  assign link.update      = update_q;
  assign link.frame_err   = ferr_q;
  assign link.stuck_high  = stuck_q;
endmodule

// File: tb/tb_pwm_decoder.sv
// Bench for pwm_decoder: table of duty patterns plus hand sequences, with an
// update scoreboard fed by the stimulus and drained by a monitor.
module tb_pwm_decoder;
  logic clock = 1'b0;
  logic enable;
  always #5 clock = ~clock;

  pwm_decoder_if link();

  pwm_decoder #(
    .PERIOD(32), .CNT_W(7), .SYNC_STAGES(2), .MATCH_FRAMES(2)
  ) dut (
    .clock(clock),
    .enable(enable),
    .link(link)
  );

  typedef struct {
    int high;
    int code;
  } vec_t;

  vec_t vecs[8];
  int   exp_q[$];
  int   n_vec = 0, n_err = 0;
  int   upd_seen = 0, exp_upd = 0, ferr_seen = 0, exp_ferr = 0;
  int   mdl_speed = 0;
  bit   mdl_valid = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, wanted %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_frame(input int high, input int per);
    for (int i = 0; i < per; i++) begin
      @(negedge clock);
      link.pwm_in = (i < high);
    end
  endtask

  task automatic expect_speed(input int code);
    if (!mdl_valid || mdl_speed != code) begin
      exp_q.push_back(code);
      exp_upd++;
    end
    mdl_speed = code;
    mdl_valid = 1'b1;
  endtask

  task automatic check_lock(input string tag);
    check({tag, "_speed"}, link.speed, mdl_speed);
    check({tag, "_valid"}, link.speed_valid, mdl_valid);
    check({tag, "_updates"}, upd_seen, exp_upd);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_speed"}, link.speed, 0);
    check({tag, "_valid"}, link.speed_valid, 0);
    check({tag, "_update"}, link.update, 0);
    check({tag, "_frame_err"}, link.frame_err, 0);
    check({tag, "_stuck"}, link.stuck_high, 0);
  endtask

  always @(negedge clock) begin
    if (!enable) begin
      if (link.update) begin
        upd_seen++;
        check("update_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("update_speed", link.speed, exp_q.pop_front());
      end
      if (link.frame_err) ferr_seen++;
      if (link.update || link.frame_err)
        check("pulse_exclusive", int'(link.update & link.frame_err), 0);
    end
  end

  initial begin
    vecs[0] = '{16, 4};
    vecs[1] = '{24, 6};
    vecs[2] = '{8, 2};
    vecs[3] = '{28, 7};
    vecs[4] = '{30, 7};
    vecs[5] = '{1, 0};
    vecs[6] = '{12, 3};
    vecs[7] = '{20, 5};

    link.pwm_in = 1'b0;
    enable = 1'b1;
    repeat (3) @(negedge clock);
    check_reset("reset");
    enable = 1'b0;

    for (int v = 0; v < 8; v++) begin
      expect_speed(vecs[v].code);
      repeat (4) drive_frame(vecs[v].high, 32);
      check_lock($sformatf("vec%0d", v));
    end

    // speed 4 -> 6: the first 24-high frame only seeds the candidate
    expect_speed(4);
    repeat (4) drive_frame(16, 32);
    check_lock("lock4");
    drive_frame(24, 32);
    drive_frame(24, 32);
    check("switch_hold_speed", link.speed, 4);
    check("switch_no_early_update", upd_seen, exp_upd);
    expect_speed(6);
    drive_frame(24, 32);
    check_lock("switch6");

    // 0% duty timeout, held long enough to saturate low_run
    expect_speed(0);
    repeat (200) begin
      @(negedge clock);
      link.pwm_in = 1'b0;
    end
    check_lock("timeout");

    // stuck high
    repeat (40) begin
      @(negedge clock);
      link.pwm_in = 1'b1;
    end
    check("stuck_set", link.stuck_high, 1);
    check("stuck_valid", link.speed_valid, 0);
    check("stuck_speed_hold", link.speed, 0);
    mdl_valid = 1'b0;
    repeat (10) begin
      @(negedge clock);
      link.pwm_in = 1'b0;
    end
    check("stuck_clear", link.stuck_high, 0);
    expect_speed(3);
    repeat (4) drive_frame(12, 32);
    check_lock("relock3");

    // short frame while locked at 2
    expect_speed(2);
    repeat (4) drive_frame(8, 32);
    check_lock("lock2");
    drive_frame(8, 20);
    exp_ferr++;
    repeat (3) drive_frame(8, 32);
    check("frame_err_count", ferr_seen, exp_ferr);
    check_lock("after_err");

    // reset mid-frame, then restart needs three rises
    @(negedge clock);
    link.pwm_in = 1'b1;
    repeat (5) @(negedge clock);
    enable = 1'b1;
    #1;
    check_reset("reset_mid");
    link.pwm_in = 1'b0;
    mdl_speed = 0;
    mdl_valid = 1'b0;
    repeat (3) @(negedge clock);
    enable = 1'b0;
    drive_frame(16, 32);
    drive_frame(16, 32);
    check("restart_no_update", upd_seen, exp_upd);
    check("restart_valid", link.speed_valid, 0);
    expect_speed(4);
    @(negedge clock);
    link.pwm_in = 1'b1;
    for (int i = 1; i < 32; i++) begin
      @(negedge clock);
      if (i == 2) check("latency_early", link.update, 0);
      if (i == 3) begin
        check("latency_update", link.update, 1);
        check("latency_speed", link.speed, 4);
      end
      link.pwm_in = (i < 16);
    end
    drive_frame(16, 32);
    check_lock("restart4");
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pwm_decoder.md
Name: pwm_decoder

Overview:
- Receive-side counterpart of the team's PWM generator.
- Samples an incoming PWM waveform (fixed 32-cycle frame, duty in steps of 4 cycles) and recovers the 3-bit speed code that produced it.
- Confirms the code over consecutive frames and flags malformed or stuck inputs.
- Sits on the consumer side of the PWM link, e.g. a board-to-board speed channel or loopback self-test.

Parameters:
PERIOD, 32, expected frame length in clock cycles (rise to rise)
CNT_W, 7, width of internal cycle counters; must hold 2*PERIOD
SYNC_STAGES, 2, flip-flops in the input synchronizer
MATCH_FRAMES, 2, consecutive identical valid frames needed to load speed

Ports:
clock  input  1  system clock, all logic on rising edge
enable  input  1  asynchronous active-high reset (codebase naming); high clears all state
pwm_in  input  1  asynchronous PWM input
speed  output  3  decoded speed code 0..7
speed_valid  output  1  level, speed holds a confirmed value
update  output  1  one-cycle pulse when speed is loaded with a new value
frame_err  output  1  one-cycle pulse on a frame whose period is not PERIOD
stuck_high  output  1  level, input held high for at least PERIOD cycles

Behaviour:
- Reset (enable=1, asynchronous): speed=0, speed_valid=0, update=0, frame_err=0, stuck_high=0, synchronizer flops=0, all counters=0, state=IDLE.
- Input path: pwm_in passes through SYNC_STAGES flops to give pwm_s, plus one delay flop pwm_d.
  - rise = pwm_s & ~pwm_d
  - fall = ~pwm_s & pwm_d
- Counters:
  - per_cnt counts cycles since the last rise; cleared to 1 on rise; saturates at all-ones.
  - high_cnt counts cycles with pwm_s=1 in the current frame; loaded with 1 on rise; saturates.
  - low_run counts consecutive pwm_s=0 cycles; cleared when pwm_s=1; saturates.
- State IDLE: the first rise after reset, stuck-high or low timeout moves to MEASURE with no decode.
- State MEASURE, on rise:
  - If per_cnt == PERIOD: code = min(7, (high_cnt + 2) >> 2).
    - If code equals the previous candidate, increment match_cnt; otherwise set candidate=code and match_cnt=1.
    - When match_cnt reaches MATCH_FRAMES, load speed<=candidate and set speed_valid<=1.
    - Pulse update in that cycle only if the loaded value differs from speed or speed_valid was 0.
  - Else: pulse frame_err, set match_cnt=0, hold speed and speed_valid.
  - Remain in MEASURE.
- Latency: the update pulse and the new speed appear in the same cycle, SYNC_STAGES+1 clocks after the pin rise that ends the confirming frame.
- Low timeout (0% duty, no rises):
  - When low_run reaches MATCH_FRAMES*PERIOD, set speed<=0 and speed_valid<=1; pulse update per the rule above.
  - Clear match_cnt and go to IDLE.
  - Fires once per low run; low_run saturation prevents repeats.
- Stuck high: when pwm_s has been 1 for PERIOD consecutive cycles:
  - Set stuck_high<=1 and speed_valid<=0, hold speed, clear match_cnt, go to IDLE.
  - stuck_high clears on the next fall.
- Simultaneous events:
  - A rise resets low_run in the same cycle, so timeout does not also fire.
  - frame_err and update can never pulse in the same cycle.
- Counter saturation: per_cnt saturated at a rise is treated as period mismatch and produces frame_err.
- Reset mid-frame: all state is discarded; decoding restarts from IDLE and needs MATCH_FRAMES+1 rises before update.

Test Plan:
- Reset, then drive generator waveform speed=4 (16 high / 16 low, period 32) -> first rise enters MEASURE; after the 3rd rise speed=4, speed_valid=1, exactly one update pulse; no further pulses while input is unchanged.
- Locked at 4, switch waveform to speed=6 (24/8) -> speed stays 4 for one frame; update and speed=6 after the second 24-high frame.
- Hold pwm_in=0 for 64+ cycles after lock at 6 -> speed=0, speed_valid=1, single update pulse; no repeat while low persists.
- Hold pwm_in=1 for 32 cycles -> stuck_high=1, speed_valid=0, speed holds; a fall clears stuck_high; valid frames relock.
- While locked at 2, inject one frame with period 20 -> frame_err pulses once, speed stays 2, match restarts; recovery needs 2 good frames.
- Boundary and reset cases:
  - high_cnt=28 decodes to 7.
  - Jittered high_cnt=30 clamps to 7.
  - high_cnt=1 decodes to 0.
  - Asserting enable mid-frame drives all outputs to reset values immediately.
